conv_encoder_213: RTL

CONV_ENCODER_213 -- requirements
Module: conv_encoder_213

---
 rtl/params_e213.sv | 21 ++
 rtl/conv_enc_213_core.sv | 30 +++
 rtl/conv_encoder_213.sv | 120 ++++++++++++
 3 files changed

// File: rtl/params_e213.sv
// Shared constants for the rate-1/2, K=4 convolutional code (encoder and decoder).
//   CodeN / CodeK / CodeM : code symbols per step (n), input bits per step (k), memory (m)
//   G0 / G1               : generator taps, MSB applies to the current input bit u,
//                           lower bits apply to S[0], S[1], S[2] in that order
//   enc_state_e           : FSM encoding shared with the decoder
package params_e213;

    localparam int unsigned CodeN = 2;
    localparam int unsigned CodeK = 1;
    localparam int unsigned CodeM = 3;

    localparam logic [CodeM:0] G0 = 4'b1101;  // octal 15
    localparam logic [CodeM:0] G1 = 4'b1111;  // octal 17

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2
    } enc_state_e;

endpackage

// File: rtl/conv_enc_213_core.sv
// Combinational encoder step: (u, S) -> (c0, c1, next S).
//   u      : current information (or tail zero) bit
//   s      : shift register, s[0] newest
//   c0, c1 : code bits from generators G0 and G1
//   next_s : shift register after u is shifted in
module conv_enc_213_core
    import params_e213::*;
(
    input  logic             u,
    input  logic [CodeM-1:0] s,
    output logic             c0,
    output logic             c1,
    output logic [CodeM-1:0] next_s
);

    logic [CodeM:0] taps;

    always_comb begin
        // taps line up with the generator masks: u in the MSB, then S[0], S[1], S[2]
        taps        = '0;
        taps[CodeM] = u;
        for (int i = 0; i < CodeM; i++) begin
            taps[CodeM-1-i] = s[i];
        end
        c0     = ^(taps & G0);
        c1     = ^(taps & G1);
        next_s = {s[CodeM-2:0], u};
    end

endmodule

// File: rtl/conv_encoder_213.sv
// Rate-1/2 convolutional encoder with zero-tail termination and a registered,
// ready/valid output stage.
//   clock, reset        : clock and synchronous active-high reset
//   in_bit, in_valid,
//   in_last, in_ready   : information bit stream; in_last marks a frame's final bit
//   Tx, Tx_valid,
//   Tx_ready, Tx_last   : code symbol {c0,c1} (c0 on Tx[1]); Tx_last on the final tail symbol
//   busy                : frame in progress
module conv_encoder_213
    import params_e213::*;
#(
    parameter int unsigned n = CodeN,
    parameter int unsigned k = CodeK,
    parameter int unsigned m = CodeM
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [k-1:0] in_bit,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [n-1:0] Tx,
    output logic         Tx_valid,
    input  logic         Tx_ready,
    output logic         Tx_last,
    output logic         busy
);

    localparam logic [1:0] TailLast = 2'(m - 1);

    enc_state_e     state_q, state_d;
    logic [m-1:0]   s_q, s_d;
    logic [1:0]     tail_cnt_q, tail_cnt_d;
    logic [n-1:0]   tx_q, tx_d;
    logic           tx_valid_q, tx_valid_d;
    logic           tx_last_q, tx_last_d;

    logic           load_ok;
    logic           accept;
    logic           tail_step;
    logic           u;
    logic           c0, c1;
    logic [m-1:0]   next_s;

    // Output register is free when empty or being drained this cycle.
    assign load_ok   = !tx_valid_q || Tx_ready;
    assign in_ready  = (state_q != TAIL) && load_ok;
    assign accept    = in_valid && in_ready;
    assign tail_step = (state_q == TAIL) && load_ok;
    assign u         = tail_step ? 1'b0 : in_bit[0];

    conv_enc_213_core u_core (
        .u      (u),
        .s      (s_q),
        .c0     (c0),
        .c1     (c1),
        .next_s (next_s)
    );

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        tail_cnt_d = tail_cnt_q;
        tx_d       = tx_q;
        tx_valid_d = tx_valid_q;
        tx_last_d  = tx_last_q;

        if (accept) begin
            s_d        = next_s;
            tx_d       = '0;
            tx_d[1]    = c0;
            tx_d[0]    = c1;
            tx_valid_d = 1'b1;
            tx_last_d  = 1'b0;
            tail_cnt_d = 2'd0;
            state_d    = in_last ? TAIL : DATA;
        end else if (tail_step) begin
            s_d        = next_s;
            tx_d       = '0;
            tx_d[1]    = c0;
            tx_d[0]    = c1;
            tx_valid_d = 1'b1;
            tx_last_d  = (tail_cnt_q == TailLast);
            if (tail_cnt_q == TailLast) begin
                tail_cnt_d = 2'd0;
                state_d    = IDLE;
            end else begin
                tail_cnt_d = tail_cnt_q + 2'd1;
            end
        end else if (Tx_ready) begin
            // Symbol drained with nothing new to load: Tx keeps its last value.
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            s_q        <= '0;
            tail_cnt_q <= 2'd0;
            tx_q       <= '0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            tail_cnt_q <= tail_cnt_d;
            tx_q       <= tx_d;
            tx_valid_q <= tx_valid_d;
            tx_last_q  <= tx_last_d;
        end
    end

    assign Tx       = tx_q;
    assign Tx_valid = tx_valid_q;
    assign Tx_last  = tx_last_q;
    assign busy     = (state_q != IDLE);

endmodule
